// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch sequencer: PC advance, next-PC select, imem req/ack, IF/ID control
// Optional statistics counters are enabled by defining FETCH_STAT_EN.
module fetch_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       imem_ack,
  input  logic       stall_in,
  input  logic       redirect_valid,
  input  logic [1:0] redirect_sel,
  output logic       imem_req,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       fetch_err
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] redirect_count
`endif
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, ERR} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             pending;
  logic [1:0]       pend_sel;
  logic [CNT_W-1:0] wait_cnt;

  // Mealy controls: live redirect beats a deferred one, which beats stall.
  always_comb begin
    pc_write    = 1'b0;
    pc_sel      = 2'd0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    case (state)
      FETCH: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            pc_write    = 1'b1;
            pc_sel      = redirect_sel;
            if_id_flush = 1'b1;
          end else if (pending) begin
            pc_write    = 1'b1;
            pc_sel      = pend_sel;
            if_id_flush = 1'b1;
          end else if (!stall_in) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_write    = 1'b1;
          pc_sel      = redirect_sel;
          if_id_flush = 1'b1;
        end else if (!stall_in) begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // imem_req is registered alongside the state so it has no input-to-output path.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= BOOT;
      imem_req  <= 1'b0;
      pending   <= 1'b0;
      pend_sel  <= 2'd0;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            wait_cnt <= '0;
            if (redirect_valid || pending) begin
              pending <= 1'b0;
            end else if (stall_in) begin
              state    <= HOLD;
              imem_req <= 1'b0;
            end
          end else begin
            if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + CNT_W'(1);
            if (redirect_valid) begin
              pending  <= 1'b1;
              pend_sel <= redirect_sel;
            end
            if (wait_cnt == TO_LAST) begin
              state     <= ERR;
              imem_req  <= 1'b0;
              fetch_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (redirect_valid || !stall_in) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            pending  <= 1'b0;
          end
        end
        default: begin
          state    <= ERR;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_STAT_EN
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (state == HOLD || (state == FETCH && !imem_ack))
        stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush)
        redirect_count <= redirect_count + 16'd1;
    end
  end
`endif

endmodule
